mult_booth: RTL and testbench

- Sequential radix-2 Booth multiplier for the multicycle MIPS datapath. It is the arithmetic counterpart to the existing divider.
- Produces the 64-bit product of RegAOut (rs) and RegBOut (rt) into HI/LO for mult/multu.
- Driven by the control unit with the same level-held Ctrl/Done handshake the divider uses.
- One clock; reset is synchronous and active-low.

---
 rtl/mult_pkg.sv | 25 ++
 rtl/booth_step.sv | 40 ++++
 rtl/mult_booth.sv | 119 +++++++++++
 tb/tb_mult_booth.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg
//   Shared definitions for the sequential Booth multiplier.
//   - mult_state_t : controller states (IDLE, RUN, DONE)
//   - MULT_WIDTH   : default operand width (MIPS word)
//   - cnt_width()  : step counter width for a given operand width
//   - MULT_CNT_W   : step counter width for the default operand width
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int MULT_WIDTH = 32;

  // The counter must be able to hold the last step index (WIDTH), so WIDTH+2
  // values keeps it safely wide for any WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 2);
  endfunction

  localparam int MULT_CNT_W = cnt_width(MULT_WIDTH);

endpackage

// File: rtl/booth_step.sv
// booth_step
//   One combinational radix-2 Booth iteration on the WIDTH+1 bit accumulator.
//   Ports:
//     a       in  WIDTH+1  current accumulator (upper half of {A,Q,q_1})
//     m       in  WIDTH+1  extended multiplicand
//     q0      in  1        current LSB of Q
//     q1      in  1        bit shifted out on the previous step
//     a_next  out WIDTH+1  accumulator after add/sub and arithmetic shift
//     q_in    out 1        bit shifted from A into the MSB of Q
//     q1_next out 1        new q_1 (the old Q LSB)
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] m,
  input  logic           q0,
  input  logic           q1,
  output logic [WIDTH:0] a_next,
  output logic           q_in,
  output logic           q1_next
);

  logic [WIDTH:0] sum;

  // 01 marks the end of a run of ones (add), 10 the start of one (subtract).
  // Sums wrap mod 2^(WIDTH+1); the final product only uses the low 2*WIDTH bits.
  always_comb begin
    sum = a;
    case ({q0, q1})
      2'b01:   sum = a + m;
      2'b10:   sum = a - m;
      default: sum = a;
    endcase
  end

  assign a_next  = {sum[WIDTH], sum[WIDTH:1]};
  assign q_in    = sum[0];
  assign q1_next = q0;

endmodule

// File: rtl/mult_booth.sv
// mult_booth
//   Sequential radix-2 Booth multiplier for mult/multu. Operands are
//   extended to WIDTH+1 bits so a single signed datapath of WIDTH+1 steps
//   covers both signed and unsigned products.
//   Ports:
//     clock      in  1      rising-edge clock
//     reset      in  1      synchronous, active-low
//     RegAOut    in  WIDTH  multiplicand (rs), sampled at start
//     RegBOut    in  WIDTH  multiplier (rt), sampled at start
//     MultSigned in  1      1 = signed (mult), 0 = unsigned (multu)
//     MultCtrl   in  1      level request, held for the whole operation
//     MultDone   out 1      result valid while MultCtrl stays high
//     MultHIOut  out WIDTH  upper half of the product
//     MultLOOut  out WIDTH  lower half of the product
module mult_booth
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] RegAOut,
  input  logic [WIDTH-1:0] RegBOut,
  input  logic             MultSigned,
  input  logic             MultCtrl,
  output logic             MultDone,
  output logic [WIDTH-1:0] MultHIOut,
  output logic [WIDTH-1:0] MultLOOut
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

  mult_state_t    state;
  logic [WIDTH:0] m_reg;
  logic [WIDTH:0] a_reg;
  logic [WIDTH:0] q_reg;
  logic           q1_reg;
  logic [CW-1:0]  step;

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] a_next;
  logic           q_in;
  logic           q1_next;

  assign a_ext = MultSigned ? {RegAOut[WIDTH-1], RegAOut} : {1'b0, RegAOut};
  assign b_ext = MultSigned ? {RegBOut[WIDTH-1], RegBOut} : {1'b0, RegBOut};

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a       (a_reg),
    .m       (m_reg),
    .q0      (q_reg[0]),
    .q1      (q1_reg),
    .a_next  (a_next),
    .q_in    (q_in),
    .q1_next (q1_next)
  );

  // The result is taken from the shifted values of the final step, so HI is
  // the low WIDTH-1 bits of the new A followed by the bit entering Q, and LO
  // is the new Q without its top bit. The two extra top bits of the
  // 2*WIDTH+2 bit register pair are only sign copies and are dropped.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      MultDone  <= 1'b0;
      MultHIOut <= '0;
      MultLOOut <= '0;
      m_reg     <= '0;
      a_reg     <= '0;
      q_reg     <= '0;
      q1_reg    <= 1'b0;
      step      <= '0;
    end else begin
      case (state)
        IDLE: begin
          MultDone <= 1'b0;
          if (MultCtrl) begin
            m_reg  <= a_ext;
            a_reg  <= '0;
            q_reg  <= b_ext;
            q1_reg <= 1'b0;
            step   <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (!MultCtrl) begin
            MultDone <= 1'b0;
            state    <= IDLE;
          end else begin
            a_reg  <= a_next;
            q_reg  <= {q_in, q_reg[WIDTH:1]};
            q1_reg <= q1_next;
            step   <= step + 1'b1;
            if (step == LAST_STEP) begin
              MultHIOut <= {a_next[WIDTH-2:0], q_in};
              MultLOOut <= q_reg[WIDTH:1];
              MultDone  <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (!MultCtrl) begin
            MultDone <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          MultDone <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_booth.sv
// tb_mult_booth
//   Scoreboard bench for mult_booth: expected products are queued when a
//   request is issued and compared when MultDone rises.
module tb_mult_booth;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [W-1:0]  RegAOut = '0;
  logic [W-1:0]  RegBOut = '0;
  logic          MultSigned = 1'b0;
  logic          MultCtrl = 1'b0;
  logic          MultDone;
  logic [W-1:0]  MultHIOut;
  logic [W-1:0]  MultLOOut;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  always #5 clock = ~clock;

  mult_booth #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .RegAOut    (RegAOut),
    .RegBOut    (RegBOut),
    .MultSigned (MultSigned),
    .MultCtrl   (MultCtrl),
    .MultDone   (MultDone),
    .MultHIOut  (MultHIOut),
    .MultLOOut  (MultLOOut)
  );

  // Reference product: plain 64-bit multiply of the extended operands.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic s);
    logic [2*W-1:0] ea;
    logic [2*W-1:0] eb;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  // Drive a request before the next rising edge (E0) and queue its result.
  task automatic start_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           input logic [2*W-1:0] exp);
    @(negedge clock);
    RegAOut    = a;
    RegBOut    = b;
    MultSigned = s;
    MultCtrl   = 1'b1;
    exp_q.push_back(exp);
  endtask

  // Count rising edges (E0 included) until MultDone is seen, bounded.
  task automatic wait_done(output int edges, output bit timeout);
    edges   = 0;
    timeout = 1'b1;
    while (edges < 100 && timeout) begin
      @(posedge clock);
      #1;
      edges++;
      if (MultDone) timeout = 1'b0;
    end
  endtask

  task automatic release_req();
    @(negedge clock);
    MultCtrl = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    MultCtrl = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (MultDone !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_done got %b want 0", MultDone);
    end
    checks++;
    if ({MultHIOut, MultLOOut} !== 64'h0) begin
      errors++; $display("[TB] FAIL reset_hilo got %h want 0", {MultHIOut, MultLOOut});
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_signed_small();
    int edges;
    bit to;
    int lows;
    logic [2*W-1:0] exp;
    start_req(32'd7, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    wait_done(edges, to);
    exp = exp_q.pop_front();
    checks++;
    if (to) begin errors++; $display("[TB] FAIL small_timeout done never rose"); end
    checks++;
    if (edges != 34) begin errors++; $display("[TB] FAIL small_latency got %0d want 34", edges); end
    checks++;
    if ({MultHIOut, MultLOOut} !== exp) begin
      errors++; $display("[TB] FAIL small_product got %h want %h", {MultHIOut, MultLOOut}, exp);
    end
    lows = 0;
    repeat (5) begin
      @(posedge clock);
      #1;
      if (MultDone !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin errors++; $display("[TB] FAIL small_hold got %0d low cycles want 0", lows); end
    release_req();
    checks++;
    if (MultDone !== 1'b0) begin errors++; $display("[TB] FAIL small_drop got %b want 0", MultDone); end
    checks++;
    if ({MultHIOut, MultLOOut} !== exp) begin
      errors++; $display("[TB] FAIL small_keep got %h want %h", {MultHIOut, MultLOOut}, exp);
    end
  endtask

  // Corner vectors with hand-derived products, followed by random ones.
  task automatic test_corners();
    logic [W-1:0]   ta[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    logic [W-1:0]   tb[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001};
    logic           ts[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [2*W-1:0] tp[4] = '{64'hFFFF_FFFE_0000_0001, 64'h0000_0000_0000_0001,
                              64'h4000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000};
    int edges;
    bit to;
    logic [2*W-1:0] exp;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rs;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        start_req(ta[i], tb[i], ts[i], tp[i]);
      end else begin
        ra = $urandom;
        rb = $urandom;
        rs = 1'($urandom_range(0, 1));
        start_req(ra, rb, rs, model(ra, rb, rs));
      end
      wait_done(edges, to);
      exp = exp_q.pop_front();
      checks++;
      if (to || edges != 34) begin
        errors++; $display("[TB] FAIL corner%0d_latency got %0d want 34", i, edges);
      end
      checks++;
      if ({MultHIOut, MultLOOut} !== exp) begin
        errors++; $display("[TB] FAIL corner%0d_product got %h want %h", i, {MultHIOut, MultLOOut}, exp);
      end
      release_req();
    end
  endtask

  // Operands are scrambled right after E0; the result must not follow them.
  task automatic test_operand_hold();
    logic [W-1:0]   ha[2] = '{32'h0000_0000, 32'h0001_0000};
    logic [W-1:0]   hb[2] = '{32'h1234_5678, 32'h0005_0000};
    logic [2*W-1:0] hp[2] = '{64'h0, 64'h0000_0005_0000_0000};
    int edges;
    bit to;
    logic [2*W-1:0] exp;
    for (int i = 0; i < 2; i++) begin
      start_req(ha[i], hb[i], 1'b0, hp[i]);
      @(posedge clock);
      #1;
      RegAOut    = 32'hFFFF_FFFF;
      RegBOut    = 32'hDEAD_BEEF;
      MultSigned = 1'b1;
      wait_done(edges, to);
      exp = exp_q.pop_front();
      checks++;
      if (to || edges != 33) begin
        errors++; $display("[TB] FAIL hold%0d_latency got %0d want 33 after E0", i, edges);
      end
      checks++;
      if ({MultHIOut, MultLOOut} !== exp) begin
        errors++; $display("[TB] FAIL hold%0d_product got %h want %h", i, {MultHIOut, MultLOOut}, exp);
      end
      release_req();
    end
  endtask

  // Relies on the previous product being HI=5, LO=0.
  task automatic test_abort();
    bit rose;
    @(negedge clock);
    RegAOut    = 32'h1111_1111;
    RegBOut    = 32'h2222_2222;
    MultSigned = 1'b0;
    MultCtrl   = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    MultCtrl = 1'b0;
    rose = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (MultDone) rose = 1'b1;
    end
    checks++;
    if (rose) begin errors++; $display("[TB] FAIL abort_done got 1 want 0"); end
    checks++;
    if ({MultHIOut, MultLOOut} !== 64'h0000_0005_0000_0000) begin
      errors++; $display("[TB] FAIL abort_hilo got %h want 0000000500000000", {MultHIOut, MultLOOut});
    end
  endtask

  task automatic test_reset_mid_run();
    int edges;
    bit to;
    logic [2*W-1:0] exp;
    @(negedge clock);
    RegAOut    = 32'h0000_0003;
    RegBOut    = 32'h0000_0009;
    MultSigned = 1'b0;
    MultCtrl   = 1'b1;
    repeat (15) @(posedge clock);
    @(negedge clock);
    reset    = 1'b0;
    MultCtrl = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (MultDone !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done got %b want 0", MultDone); end
    checks++;
    if ({MultHIOut, MultLOOut} !== 64'h0) begin
      errors++; $display("[TB] FAIL midreset_hilo got %h want 0", {MultHIOut, MultLOOut});
    end
    @(negedge clock);
    reset = 1'b1;
    start_req(32'hFFFF_FFF0, 32'h0000_0100, 1'b1, model(32'hFFFF_FFF0, 32'h0000_0100, 1'b1));
    wait_done(edges, to);
    exp = exp_q.pop_front();
    checks++;
    if (to || edges != 34) begin errors++; $display("[TB] FAIL postreset_latency got %0d want 34", edges); end
    checks++;
    if ({MultHIOut, MultLOOut} !== exp) begin
      errors++; $display("[TB] FAIL postreset_product got %h want %h", {MultHIOut, MultLOOut}, exp);
    end
    release_req();
  endtask

  task automatic test_back_to_back();
    int edges;
    bit to;
    int lows;
    logic [2*W-1:0] exp;
    start_req(32'h0000_1234, 32'h0000_5678, 1'b0, 64'h0000_0000_0626_0060);
    wait_done(edges, to);
    exp = exp_q.pop_front();
    checks++;
    if ({MultHIOut, MultLOOut} !== exp) begin
      errors++; $display("[TB] FAIL b2b_first got %h want %h", {MultHIOut, MultLOOut}, exp);
    end
    lows = 0;
    repeat (50) begin
      @(posedge clock);
      #1;
      if (MultDone !== 1'b1) lows++;
    end
    checks++;
    if (lows != 0) begin errors++; $display("[TB] FAIL b2b_no_restart got %0d low cycles want 0", lows); end
    @(negedge clock);
    MultCtrl = 1'b0;
    start_req(32'hFFFF_FFFE, 32'h7FFF_FFFF, 1'b1, model(32'hFFFF_FFFE, 32'h7FFF_FFFF, 1'b1));
    wait_done(edges, to);
    exp = exp_q.pop_front();
    checks++;
    if (to || edges != 34) begin errors++; $display("[TB] FAIL b2b_latency got %0d want 34", edges); end
    checks++;
    if ({MultHIOut, MultLOOut} !== exp) begin
      errors++; $display("[TB] FAIL b2b_second got %h want %h", {MultHIOut, MultLOOut}, exp);
    end
    release_req();
  endtask

  initial begin
    test_reset();
    test_signed_small();
    test_corners();
    test_operand_hold();
    test_abort();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
